// File: rtl/pad_input_receiver.sv
// Pad input conditioner: synchroniser, debounce FSM and saturating edge counter.
// Define PAD_RX_BOTH_EDGES_EN to count falling edges as well as rising edges.
module pad_input_receiver #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_di,
    input  logic             en,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_ovf
);

    // state   | meaning
    // LO      | debounced level is 0
    // PEND_HI | synchronised input is 1, counting towards a level change to 1
    // HI      | debounced level is 1
    // PEND_LO | synchronised input is 0, counting towards a level change to 0
    typedef enum logic [1:0] {LO, PEND_HI, HI, PEND_LO} state_t;

    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

    state_t                 state;
    logic [7:0]             dcnt;
    logic [7:0]             dcnt_inc;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   done_hi;
    logic                   done_lo;
    logic                   cnt_evt;

    assign s        = sync[SYNC_STAGES-1];
    assign dcnt_inc = dcnt + 8'd1;

    // dcnt holds the number of qualifying cycles already seen, so this cycle makes dcnt+1
    assign done_hi = en && s &&
                     ((state == LO && DB == 8'd1) || (state == PEND_HI && dcnt_inc == DB));
    assign done_lo = en && !s &&
                     ((state == HI && DB == 8'd1) || (state == PEND_LO && dcnt_inc == DB));

`ifdef PAD_RX_BOTH_EDGES_EN
    assign cnt_evt = done_hi || done_lo;
`else
    assign cnt_evt = done_hi;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_di};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LO;
            dcnt  <= 8'd0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= done_hi;
            fall <= done_lo;
            if (done_hi) begin
                state <= HI;
                level <= 1'b1;
                dcnt  <= 8'd0;
            end else if (done_lo) begin
                state <= LO;
                level <= 1'b0;
                dcnt  <= 8'd0;
            end else if (en) begin
                case (state)
                    LO: begin
                        if (s) begin
                            state <= PEND_HI;
                            dcnt  <= 8'd1;
                        end
                    end
                    PEND_HI: begin
                        if (s) begin
                            dcnt <= dcnt_inc;
                        end else begin
                            state <= LO;
                            dcnt  <= 8'd0;
                        end
                    end
                    HI: begin
                        if (!s) begin
                            state <= PEND_LO;
                            dcnt  <= 8'd1;
                        end
                    end
                    PEND_LO: begin
                        if (!s) begin
                            dcnt <= dcnt_inc;
                        end else begin
                            state <= HI;
                            dcnt  <= 8'd0;
                        end
                    end
                    default: begin
                        state <= LO;
                        dcnt  <= 8'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else if (clr) begin
            edge_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else if (cnt_evt) begin
            if (edge_cnt == {CNT_W{1'b1}}) begin
                cnt_ovf <= 1'b1;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pad_input_receiver.sv
// Directed bench for pad_input_receiver: a default-width instance and a 2-bit counter
// instance share the same stimulus.
module tb_pad_input_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        pad_di;
    logic        en;
    logic        clr;
    logic        level, rise, fall, cnt_ovf;
    logic [15:0] edge_cnt;
    logic        level_s, rise_s, fall_s, cnt_ovf_s;
    logic [1:0]  edge_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pad_input_receiver #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pad_di(pad_di), .en(en), .clr(clr),
        .level(level), .rise(rise), .fall(fall), .edge_cnt(edge_cnt), .cnt_ovf(cnt_ovf)
    );

    pad_input_receiver #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .pad_di(pad_di), .en(en), .clr(clr),
        .level(level_s), .rise(rise_s), .fall(fall_s), .edge_cnt(edge_cnt_s), .cnt_ovf(cnt_ovf_s)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pad_di = 1'b1; en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({level, rise, fall, edge_cnt, cnt_ovf} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got level=%b rise=%b fall=%b cnt=%0d ovf=%b, want all 0",
                     level, rise, fall, edge_cnt, cnt_ovf);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({level, rise, fall, edge_cnt} !== 18'd0) begin
                errors++;
                $display("FAIL idle_en0 cycle %0d: got level=%b rise=%b fall=%b cnt=%0d, want 0",
                         i, level, rise, fall, edge_cnt);
            end
        end
        pad_di = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_glitch();
        int rises = 0;
        int highs = 0;
        @(negedge clk);
        pad_di = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pad_di = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rise) rises++;
            if (level) highs++;
        end
        checks++;
        if (highs !== 0 || rises !== 0) begin
            errors++;
            $display("FAIL glitch_level: got high_cycles=%0d rises=%0d, want 0 and 0", highs, rises);
        end
        checks++;
        if (edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL glitch_cnt: got %0d, want 0", edge_cnt);
        end
    endtask

    task automatic test_clean_rise();
        int rises = 0;
        int first = 0;
        @(negedge clk);
        pad_di = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (rise) rises++;
            if (level && first == 0) first = n;
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL rise_latency: level rose on edge %0d, want edge 6", first);
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL rise_pulses: got %0d, want 1", rises);
        end
        checks++;
        if (edge_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rise_cnt: got %0d, want 1", edge_cnt);
        end
    endtask

    task automatic test_fall_count();
        int falls = 0;
        int first = 0;
        logic [15:0] exp_cnt;
`ifdef PAD_RX_BOTH_EDGES_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd1;
`endif
        @(negedge clk);
        pad_di = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (fall) falls++;
            if (!level && first == 0) first = n;
        end
        checks++;
        if (first !== 6 || falls !== 1) begin
            errors++;
            $display("FAIL fall_pulse: got edge=%0d pulses=%0d, want edge 6 and 1 pulse", first, falls);
        end
        checks++;
        if (edge_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL fall_cnt: got %0d, want %0d", edge_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        int ev = 0;
        logic [1:0] exp_c;
        logic exp_o;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (edge_cnt_s !== 2'd0 || cnt_ovf_s !== 1'b0 || edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear: got sat=%0d ovf=%b main=%0d, want 0 0 0", edge_cnt_s, cnt_ovf_s, edge_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            pad_di = 1'b1;
            repeat (10) @(negedge clk);
            ev++;
            exp_c = (ev >= 3) ? 2'd3 : 2'(ev);
            exp_o = (ev >= 4);
            checks++;
            if (edge_cnt_s !== exp_c || cnt_ovf_s !== exp_o) begin
                errors++;
                $display("FAIL sat_rise %0d: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                         k, edge_cnt_s, cnt_ovf_s, exp_c, exp_o);
            end
            pad_di = 1'b0;
            repeat (10) @(negedge clk);
`ifdef PAD_RX_BOTH_EDGES_EN
            ev++;
`endif
            exp_c = (ev >= 3) ? 2'd3 : 2'(ev);
            exp_o = (ev >= 4);
            checks++;
            if (edge_cnt_s !== exp_c || cnt_ovf_s !== exp_o) begin
                errors++;
                $display("FAIL sat_fall %0d: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                         k, edge_cnt_s, cnt_ovf_s, exp_c, exp_o);
            end
        end
    endtask

    task automatic test_clr_with_rise();
        @(negedge clk);
        pad_di = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (rise_s !== 1'b1 || edge_cnt_s !== 2'd0 || cnt_ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_rise: got rise=%b cnt=%0d ovf=%b, want 1 0 0", rise_s, edge_cnt_s, cnt_ovf_s);
        end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (edge_cnt_s !== 2'd0 || edge_cnt !== 16'd0 || level !== 1'b1) begin
            errors++;
            $display("FAIL clr_hold: got sat=%0d main=%0d level=%b, want 0 0 1", edge_cnt_s, edge_cnt, level);
        end
        pad_di = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce();
        int first = 0;
        @(negedge clk);
        pad_di = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut.dcnt !== 8'd1 || level !== 1'b0) begin
            errors++;
            $display("FAIL pend_hi_entry: got dcnt=%0d level=%b, want 1 0", dut.dcnt, level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (level !== 1'b0 || dut.dcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: got level=%b dcnt=%0d, want 0 0", level, dut.dcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (rise && first == 0) first = n;
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL reset_mid_relatency: rise on edge %0d, want edge 6", first);
        end
    endtask

    initial begin
        rst = 1'b1; pad_di = 1'b0; en = 1'b0; clr = 1'b0;
        test_reset();
        test_glitch();
        test_clean_rise();
        test_fall_count();
        test_saturation();
        test_clr_with_rise();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
